// File: rtl/imm_encoder.sv
// Generic FIFO: DEPTH-entry circular buffer, pointer wrap relies on power-of-2 DEPTH.
// Latency: a pushed entry is visible on o_pop_* right after the push edge when empty.
// Backpressure: o_push_rdy = count < DEPTH (forced low in reset), independent of i_pop_rdy.
//
// Ports: i_push_vld/o_push_rdy/i_push_dat write side, o_pop_vld/i_pop_rdy/o_pop_dat read side.
module fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push_vld,
    output logic         o_push_rdy,
    input  logic [W-1:0] i_push_dat,
    output logic         o_pop_vld,
    input  logic         i_pop_rdy,
    output logic [W-1:0] o_pop_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    // Ready comes from registered occupancy only, so a pop in the same cycle
    // never lets a beat into a full FIFO. Gated by rst_n so nothing is taken
    // while reset is held.
    assign o_push_rdy = rst_n & (r_count < FULL_CNT);
    assign o_pop_vld  = (r_count != '0);
    assign o_pop_dat  = o_pop_vld ? r_mem[r_rd_ptr] : '0;

    assign w_push = i_push_vld & o_push_rdy;
    assign w_pop  = o_pop_vld & i_pop_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: contents are only observable when the count says so.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
    end
endmodule

// RV32I immediate encoder: packs in_imm into the format's bit positions of in_base, flags unrepresentable immediates.
// Latency: 1 cycle (accept edge -> visible on out_*) when the FIFO is empty; 1 beat/cycle sustained.
// Backpressure: in_ready = FIFO not full (registered state), independent of out_ready.
//
// Ports: clk, rst_n; in_valid/in_ready/in_itype/in_base/in_imm input stream;
//        out_valid/out_ready/out_instr/out_err output stream; err_count saturating error count.
module imm_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_itype,
    input  logic [31:0]      in_base,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count
);
    localparam logic [2:0] IT_I = 3'b001;
    localparam logic [2:0] IT_B = 3'b010;
    localparam logic [2:0] IT_S = 3'b011;
    localparam logic [2:0] IT_U = 3'b100;
    localparam logic [2:0] IT_J = 3'b101;

    typedef struct packed {
        logic        err;
        logic [31:0] instr;
    } entry_t;

    entry_t           w_enc;
    entry_t           w_head;
    logic             w_accept;
    logic             w_sx11_ok;
    logic             w_sx12_ok;
    logic             w_sx20_ok;
    logic [CNT_W-1:0] r_err_count;

    // Sign-extension checks: the bits above the field's sign bit must all
    // equal that sign bit, i.e. be all ones or all zeros.
    assign w_sx11_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign w_sx12_ok = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign w_sx20_ok = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    always_comb begin
        w_enc.instr = in_base;
        w_enc.err   = 1'b0;
        case (in_itype)
            IT_I: begin
                w_enc.instr = {in_imm[11:0], in_base[19:0]};
                w_enc.err   = ~w_sx11_ok;
            end
            IT_S: begin
                w_enc.instr = {in_imm[11:5], in_base[24:12], in_imm[4:0], in_base[6:0]};
                w_enc.err   = ~w_sx11_ok;
            end
            IT_B: begin
                w_enc.instr = {in_imm[12], in_imm[10:5], in_base[24:12],
                               in_imm[4:1], in_imm[11], in_base[6:0]};
                w_enc.err   = ~w_sx12_ok | in_imm[0];
            end
            IT_U: begin
                w_enc.instr = {in_imm[31:12], in_base[11:0]};
                w_enc.err   = |in_imm[11:0];
            end
            IT_J: begin
                w_enc.instr = {in_imm[20], in_imm[10:1], in_imm[11],
                               in_imm[19:12], in_base[11:0]};
                w_enc.err   = ~w_sx20_ok | in_imm[0];
            end
            default: begin
                // R and the unused codes pass the base word through untouched.
                w_enc.instr = in_base;
                w_enc.err   = 1'b0;
            end
        endcase
    end

    assign w_accept = in_valid & in_ready;

    fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push_vld (in_valid),
        .o_push_rdy (in_ready),
        .i_push_dat (w_enc),
        .o_pop_vld  (out_valid),
        .i_pop_rdy  (out_ready),
        .o_pop_dat  (w_head)
    );

    assign out_instr = w_head.instr;
    assign out_err   = w_head.err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (w_accept && w_enc.err && !(&r_err_count)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign err_count = r_err_count;
endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed vectors, backpressure, streaming, async reset, random traffic.
// Reference: arithmetic range/alignment model plus a standard RV32I immediate decoder.
// Inputs change 1 time unit after posedge; all observation happens on negedge.
module tb_imm_encoder;
    localparam int DEPTH = 2;
    localparam int CNT_MAX = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_itype = '0;
    logic [31:0] in_base = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        out_err;
    logic [3:0]  err_count;

    imm_encoder #(.DEPTH(DEPTH), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_itype  (in_itype),
        .in_base   (in_base),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Value actually representable after truncation to the format's field.
    function automatic logic [31:0] trunc_imm(input logic [2:0] t, input logic [31:0] i);
        case (t)
            3'd1, 3'd3: return ((i & 32'h0000_0FFF) ^ 32'h0000_0800) - 32'h0000_0800;
            3'd2:       return ((i & 32'h0000_1FFE) ^ 32'h0000_1000) - 32'h0000_1000;
            3'd5:       return ((i & 32'h001F_FFFE) ^ 32'h0010_0000) - 32'h0010_0000;
            3'd4:       return i & 32'hFFFF_F000;
            default:    return i;
        endcase
    endfunction

    function automatic bit exp_err(input logic [2:0] t, input logic [31:0] i);
        return trunc_imm(t, i) != i;
    endfunction

    function automatic logic [31:0] imm_mask(input logic [2:0] t);
        case (t)
            3'd1:       return 32'hFFF0_0000;
            3'd2, 3'd3: return 32'hFE00_0F80;
            3'd4, 3'd5: return 32'hFFFF_F000;
            default:    return 32'h0000_0000;
        endcase
    endfunction

    // Standard RV32I immediate decoder.
    function automatic logic [31:0] decode(input logic [31:0] x, input logic [2:0] t);
        case (t)
            3'd1:    return {{20{x[31]}}, x[31:20]};
            3'd3:    return {{20{x[31]}}, x[31:25], x[11:7]};
            3'd2:    return {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
            3'd4:    return {x[31:12], 12'b0};
            3'd5:    return {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    typedef struct {
        logic [2:0]  t;
        logic [31:0] b;
        logic [31:0] i;
        bit          has_exp;
        logic [31:0] exp_instr;
    } beat_t;

    beat_t       q[$];
    int          m_errcnt = 0;
    bit          dir_has = 0;
    logic [31:0] dir_val = '0;
    int          stalls = 0;

    // Monitor: handshakes seen at negedge take effect at the following posedge.
    initial begin
        forever begin
            beat_t e;
            logic [31:0] msk;
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                m_errcnt = 0;
            end else begin
                chk_eq("in_ready", in_ready, q.size() < DEPTH);
                chk_eq("out_valid", out_valid, q.size() != 0);
                chk_eq("err_count", err_count, m_errcnt);
                if (out_valid && out_ready && q.size() > 0) begin
                    e = q.pop_front();
                    msk = imm_mask(e.t);
                    chk_eq("out_err", out_err, exp_err(e.t, e.i));
                    chk_eq("fields", out_instr & ~msk, e.b & ~msk);
                    if (msk != 32'h0)
                        chk_eq("imm_roundtrip", decode(out_instr, e.t), trunc_imm(e.t, e.i));
                    if (e.has_exp)
                        chk_eq("instr", out_instr, e.exp_instr);
                end
                if (in_valid && in_ready) begin
                    e.t = in_itype; e.b = in_base; e.i = in_imm;
                    e.has_exp = dir_has; e.exp_instr = dir_val;
                    q.push_back(e);
                    if (exp_err(in_itype, in_imm) && m_errcnt < CNT_MAX) m_errcnt++;
                end
            end
        end
    end

    // Offer one beat and hold it until accepted (bounded). Leaves in_valid high.
    task automatic send(input logic [2:0] t, input logic [31:0] b, input logic [31:0] i,
                        input bit he, input logic [31:0] ev);
        int g;
        bit acc;
        g = 0;
        acc = 0;
        in_itype = t; in_base = b; in_imm = i;
        dir_has = he; dir_val = ev;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            g++;
        end while (!acc && g < 200);
        chk_eq("send_accepted", acc, 1'b1);
        stalls += g - 1;
    endtask

    task automatic drain(output int cyc);
        cyc = 0;
        while (q.size() != 0 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk_eq("drain_empty", q.size(), 0);
    endtask

    logic [31:0] bnd [12];

    function automatic logic [31:0] gen_imm();
        case ($urandom_range(0, 5))
            0:       return $urandom;
            1:       return $urandom_range(0, 4095) - 32'd2048;
            2:       return ($urandom_range(0, 8191) - 32'd4096) & ~32'd1;
            3:       return ($urandom_range(0, 2097151) - 32'd1048576) & ~32'd1;
            4:       return $urandom & 32'hFFFF_F000;
            default: return bnd[$urandom_range(0, 11)];
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bnd = '{32'd2047, -32'd2048, 32'd2048, -32'd2049, 32'd4094, -32'd4096,
                32'd4096, 32'd4095, 32'd1048574, -32'd1048576, 32'd1048576, 32'd1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_in_ready", in_ready, 1'b0);
        chk_eq("rst_out_valid", out_valid, 1'b0);
        chk_eq("rst_out_instr", out_instr, 32'h0);
        chk_eq("rst_out_err", out_err, 1'b0);
        chk_eq("rst_err_count", err_count, 4'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        out_ready = 1'b1;
        send(3'd1, 32'h0000_0013, 32'hFFFF_FFFF, 1, 32'hFFF0_0013);
        send(3'd3, 32'h0000_2023, 32'd8,         1, 32'h0000_2423);
        send(3'd4, 32'h0000_0037, 32'h1234_5000, 1, 32'h1234_5037);
        send(3'd5, 32'h0000_006F, -32'd4,        1, 32'hFFDF_F06F);
        send(3'd2, 32'h0000_0063, 32'd3,         0, 32'h0);
        in_valid = 1'b0;
        drain(cyc);
        chk_eq("errcnt_after_b", err_count, 4'h1);

        // Fill with out_ready low, verify latency, full stall, then ordered drain
        out_ready = 1'b0;
        send(3'd1, 32'h0000_0093, 32'd5, 1, 32'h0050_0093);
        chk_eq("lat_out_valid", out_valid, 1'b1);
        chk_eq("lat_out_instr", out_instr, 32'h0050_0093);
        send(3'd1, 32'h0000_0113, 32'd6, 1, 32'h0060_0113);
        send_hold_full();
        out_ready = 1'b1;
        drain(cyc);
        chk_eq("drain_cycles", cyc, DEPTH);

        // Full-rate streaming
        stalls = 0;
        for (int k = 0; k < 40; k++) begin
            logic [2:0] t;
            t = 3'($urandom_range(0, 7));
            send(t, $urandom, gen_imm(), 0, 32'h0);
        end
        in_valid = 1'b0;
        drain(cyc);
        chk_eq("stream_stalls", stalls, 0);

        // Async reset with one entry queued
        out_ready = 1'b0;
        send(3'd2, 32'h0000_0063, 32'd1, 0, 32'h0);
        in_valid = 1'b0;
        chk_eq("pre_rst_valid", out_valid, 1'b1);
        chk_eq("pre_rst_nonzero_cnt", err_count != 4'h0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("arst_out_valid", out_valid, 1'b0);
        chk_eq("arst_in_ready", in_ready, 1'b0);
        chk_eq("arst_out_instr", out_instr, 32'h0);
        chk_eq("arst_out_err", out_err, 1'b0);
        chk_eq("arst_err_count", err_count, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_eq("post_rst_out_valid", out_valid, 1'b0);
        chk_eq("post_rst_in_ready", in_ready, 1'b1);

        // Random traffic with random backpressure
        dir_has = 0;
        for (int k = 0; k < 600; k++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_itype  = 3'($urandom_range(0, 7));
            in_base   = $urandom;
            in_imm    = gen_imm();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain(cyc);

        // Force saturation of the error counter
        for (int k = 0; k < 20; k++) send(3'd4, 32'h0000_0037, 32'd1, 0, 32'h0);
        in_valid = 1'b0;
        drain(cyc);
        chk_eq("errcnt_saturated", err_count, 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Offer a third beat while full: it must not be taken, and in_ready stays low.
    task automatic send_hold_full();
        in_itype = 3'd1; in_base = 32'h0000_0193; in_imm = 32'd7;
        dir_has = 1; dir_val = 32'h0070_0193;
        in_valid = 1'b1;
        @(negedge clk);
        chk_eq("full_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        chk_eq("full_count_held", q.size(), DEPTH);
        in_valid = 1'b0;
    endtask
endmodule
